// File: rtl/spi_slave_module_if.sv
// Host/SPI signal bundle for spi_slave_module; rx_overflow exists only when
// SPI_SLAVE_OVERFLOW_EN is defined.
interface spi_slave_module_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  spiClk;
  logic                  cs;
  logic                  mosi;
  logic                  miso;
  logic [ADDR_WIDTH-1:0] tx_addr;
  logic [DATA_WIDTH-1:0] tx_byte;
  logic                  tx_wr;
  logic [ADDR_WIDTH-1:0] rx_addr;
  logic [DATA_WIDTH-1:0] rx_byte;
  logic                  rx_rd;
  logic [ADDR_WIDTH:0]   rx_count;
  logic                  io_complete;
`ifdef SPI_SLAVE_OVERFLOW_EN
  logic                  rx_overflow;
`endif

  modport slave (
    input  spiClk, cs, mosi, tx_addr, tx_byte, tx_wr, rx_addr, rx_rd,
    output miso, rx_byte, rx_count, io_complete
`ifdef SPI_SLAVE_OVERFLOW_EN
    , output rx_overflow
`endif
  );

  modport master (
    output spiClk, cs, mosi, tx_addr, tx_byte, tx_wr, rx_addr, rx_rd,
    input  miso, rx_byte, rx_count, io_complete
`ifdef SPI_SLAVE_OVERFLOW_EN
    , input rx_overflow
`endif
  );
endinterface

// File: rtl/spi_slave_module.sv
// SPI mode-0 slave with host-side TX/RX byte buffers, oversampled on sysClk.
// Optional macro SPI_SLAVE_OVERFLOW_EN: drop bytes past capacity and flag rx_overflow.
module spi_slave_module #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input logic               sysClk,
  input logic               reset,
  spi_slave_module_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {SIdle, SLoad, SShift, SStore, SDone} state_e;

  logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [DEPTH];

  // [0],[1] form the synchronizer; [2] is the previous synchronized value
  logic [2:0] sclk_sync_q;
  logic [2:0] cs_sync_q;
  logic [1:0] mosi_sync_q;

  state_e                state_q,    state_d;
  logic [ADDR_WIDTH-1:0] tx_idx_q,   tx_idx_d;
  logic [ADDR_WIDTH-1:0] rx_idx_q,   rx_idx_d;
  logic [ADDR_WIDTH:0]   rx_count_q, rx_count_d;
  logic [CW-1:0]         bit_cnt_q,  bit_cnt_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic                  miso_q,     miso_d;
  logic                  arm_q,      arm_d;
  logic                  flush_q,    flush_d;
  logic [DATA_WIDTH-1:0] rx_byte_q;
  logic                  rx_we;
`ifdef SPI_SLAVE_OVERFLOW_EN
  logic                  ovf_q,      ovf_d;
`endif

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  // arm_q blocks the artificial fall seen when reset releases with cs already low
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2] & arm_q;

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], bus.spiClk};
      cs_sync_q   <= {cs_sync_q[1:0], bus.cs};
      mosi_sync_q <= {mosi_sync_q[0], bus.mosi};
    end
  end

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      state_q    <= SIdle;
      tx_idx_q   <= '0;
      rx_idx_q   <= '0;
      rx_count_q <= '0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      miso_q     <= 1'b0;
      arm_q      <= 1'b0;
      flush_q    <= 1'b0;
`ifdef SPI_SLAVE_OVERFLOW_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_idx_q   <= tx_idx_d;
      rx_idx_q   <= rx_idx_d;
      rx_count_q <= rx_count_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      miso_q     <= miso_d;
      arm_q      <= arm_d;
      flush_q    <= flush_d;
`ifdef SPI_SLAVE_OVERFLOW_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_idx_d   = tx_idx_q;
    rx_idx_d   = rx_idx_q;
    rx_count_d = rx_count_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    miso_d     = miso_q;
    arm_d      = arm_q | (flush_q & cs_sync_q[0]);
    flush_d    = 1'b1;
    rx_we      = 1'b0;
`ifdef SPI_SLAVE_OVERFLOW_EN
    ovf_d      = ovf_q;
`endif

    case (state_q)
      SIdle: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d    = SLoad;
          rx_count_d = '0;
          tx_idx_d   = '0;
          rx_idx_d   = '0;
`ifdef SPI_SLAVE_OVERFLOW_EN
          ovf_d      = 1'b0;
`endif
        end
      end
      SLoad: begin
        tx_shift_d = tx_mem[tx_idx_q];
        miso_d     = tx_mem[tx_idx_q][DATA_WIDTH-1];
        bit_cnt_d  = '0;
        state_d    = SShift;
      end
      SShift: begin
        if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync_q[1]};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CW'(DATA_WIDTH - 1)) state_d = SStore;
        end else if (sclk_fall && bit_cnt_q != '0) begin
          // the fall trailing the previous byte's last rise arrives with bit_cnt_q==0
          tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          miso_d     = tx_shift_q[DATA_WIDTH-2];
        end
      end
      SStore: begin
        tx_idx_d = tx_idx_q + 1'b1;
        state_d  = SLoad;
        if (rx_count_q == FULL) begin
`ifdef SPI_SLAVE_OVERFLOW_EN
          ovf_d    = 1'b1;
`else
          rx_we    = 1'b1;
          rx_idx_d = rx_idx_q + 1'b1;
`endif
        end else begin
          rx_we      = 1'b1;
          rx_idx_d   = rx_idx_q + 1'b1;
          rx_count_d = rx_count_q + 1'b1;
        end
      end
      SDone: begin
        miso_d  = 1'b0;
        state_d = SIdle;
      end
      default: state_d = SIdle;
    endcase

    if (cs_rise && state_q != SIdle && state_q != SDone) state_d = SDone;
  end

  // Buffers are deliberately not reset
  always_ff @(posedge sysClk) begin
    if (!bus.tx_wr) tx_mem[bus.tx_addr] <= bus.tx_byte;
    if (rx_we)      rx_mem[rx_idx_q]    <= rx_shift_q;
  end

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset)           rx_byte_q <= '0;
    else if (!bus.rx_rd) rx_byte_q <= rx_mem[bus.rx_addr];
  end

  assign bus.miso        = miso_q & ~bus.cs;
  assign bus.rx_byte     = rx_byte_q;
  assign bus.rx_count    = rx_count_q;
  assign bus.io_complete = (state_q == SDone);
`ifdef SPI_SLAVE_OVERFLOW_EN
  assign bus.rx_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_spi_slave_module.sv
// Directed bench for spi_slave_module: bit-banged SPI master plus host buffer
// accesses, expected bytes queued at stimulus time and popped on output.
module tb_spi_slave_module;

  logic sysClk = 1'b0;
  logic reset  = 1'b1;

  spi_slave_module_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  spi_slave_module #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .sysClk (sysClk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 sysClk = ~sysClk;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned io_cnt = 0;
  logic [7:0]  sb_q [$];
  logic [7:0]  txm [16];

  always @(posedge sysClk) if (bus.io_complete === 1'b1) io_cnt++;

  initial begin
    #500us;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int unsigned nbits, output logic [7:0] rx);
    rx = '0;
    for (int unsigned i = 0; i < nbits; i++) begin
      bus.mosi = tx[7-i];
      #40;
      rx[7-i] = bus.miso;
      bus.spiClk = 1'b1;
      #40;
      bus.spiClk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] tx, input logic [7:0] exp_miso);
    logic [7:0] r;
    sb_q.push_back(exp_miso);
    spi_xfer(tx, 8, r);
    check("miso_byte", r, sb_q.pop_front());
  endtask

  task automatic cs_begin();
    bus.cs = 1'b0;
    #100;
  endtask

  task automatic cs_end();
    #40;
    bus.cs = 1'b1;
    #200;
  endtask

  task automatic tx_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge sysClk);
    bus.tx_addr = a;
    bus.tx_byte = d;
    bus.tx_wr   = 1'b0;
    @(negedge sysClk);
    bus.tx_wr   = 1'b1;
  endtask

  task automatic rx_read(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] obs;
    sb_q.push_back(exp);
    @(negedge sysClk);
    bus.rx_addr = a;
    bus.rx_rd   = 1'b0;
    @(negedge sysClk);
    obs = bus.rx_byte;
    bus.rx_rd = 1'b1;
    check(tag, obs, sb_q.pop_front());
  endtask

  initial begin
    int unsigned io0;
    logic [7:0]  r;

    bus.spiClk = 1'b0; bus.cs = 1'b1; bus.mosi = 1'b0;
    bus.tx_addr = '0; bus.tx_byte = '0; bus.tx_wr = 1'b1;
    bus.rx_addr = '0; bus.rx_rd = 1'b1;

    // reset state
    repeat (4) @(negedge sysClk);
    check("rst_rx_count", bus.rx_count, 0);
    check("rst_io_complete", bus.io_complete, 0);
    check("rst_miso", bus.miso, 0);
    check("rst_rx_byte", bus.rx_byte, 0);
`ifdef SPI_SLAVE_OVERFLOW_EN
    check("rst_overflow", bus.rx_overflow, 0);
`endif
    @(negedge sysClk) reset = 1'b0;
    repeat (4) @(negedge sysClk);

    // TX preload: first four from the scenario, rest a fixed pattern
    txm[0] = 8'hA5; txm[1] = 8'h3C; txm[2] = 8'hFF; txm[3] = 8'h00;
    for (int unsigned i = 4; i < 16; i++) txm[i] = 8'(i * 19 + 1);
    for (int unsigned i = 0; i < 16; i++) tx_write(4'(i), txm[i]);

    // four-byte transaction
    io0 = io_cnt;
    cs_begin();
    send_byte(8'h11, txm[0]);
    send_byte(8'h22, txm[1]);
    send_byte(8'h33, txm[2]);
    send_byte(8'h44, txm[3]);
    cs_end();
    check("t1_rx_count", bus.rx_count, 4);
    check("t1_io_pulses", io_cnt - io0, 1);
    check("t1_miso_idle", bus.miso, 0);
    rx_read("t1_rx0", 4'd0, 8'h11);
    rx_read("t1_rx1", 4'd1, 8'h22);
    rx_read("t1_rx2", 4'd2, 8'h33);
    rx_read("t1_rx3", 4'd3, 8'h44);
    @(negedge sysClk) bus.rx_addr = 4'd0;
    repeat (2) @(negedge sysClk);
    check("t1_rx_byte_hold", bus.rx_byte, 8'h44);

    // cs rises partway through the second byte
    io0 = io_cnt;
    cs_begin();
    send_byte(8'h5E, txm[0]);
    spi_xfer(8'h99, 5, r);
    cs_end();
    check("t2_rx_count", bus.rx_count, 1);
    check("t2_io_pulses", io_cnt - io0, 1);
    rx_read("t2_rx0", 4'd0, 8'h5E);
    rx_read("t2_rx1_unchanged", 4'd1, 8'h22);

    // host TX write while byte 0 is shifting
    cs_begin();
    fork
      send_byte(8'h01, txm[0]);
      begin
        #200;
        tx_write(4'd1, 8'h77);
      end
    join
    txm[1] = 8'h77;
    send_byte(8'h02, txm[1]);
    cs_end();
    check("t3_rx_count", bus.rx_count, 2);

    // 17 bytes into a 16-deep buffer; TX wraps back to entry 0
    io0 = io_cnt;
    cs_begin();
    for (int unsigned i = 0; i < 17; i++) send_byte(8'(8'h80 + i), txm[i % 16]);
    cs_end();
    check("t4_rx_count_sat", bus.rx_count, 16);
    check("t4_io_pulses", io_cnt - io0, 1);
    rx_read("t4_rx15", 4'd15, 8'h8F);
`ifdef SPI_SLAVE_OVERFLOW_EN
    check("t4_overflow", bus.rx_overflow, 1);
    rx_read("t4_rx0_intact", 4'd0, 8'h80);
`else
    rx_read("t4_rx0_wrapped", 4'd0, 8'h90);
`endif

    // reset mid-byte, then a fresh one-byte transaction
    cs_begin();
    spi_xfer(8'hFF, 3, r);
    @(negedge sysClk) reset = 1'b1;
    io0 = io_cnt;
    repeat (5) @(negedge sysClk);
    check("t5_rst_rx_count", bus.rx_count, 0);
    check("t5_rst_miso", bus.miso, 0);
    check("t5_rst_io", bus.io_complete, 0);
`ifdef SPI_SLAVE_OVERFLOW_EN
    check("t5_rst_overflow", bus.rx_overflow, 0);
`endif
    @(negedge sysClk) reset = 1'b0;
    #300;
    bus.cs = 1'b1;
    #200;
    check("t5_no_io_after_reset", io_cnt - io0, 0);
    cs_begin();
    send_byte(8'h5A, txm[0]);
    cs_end();
    check("t5_rx_count", bus.rx_count, 1);
    check("t5_io_pulses", io_cnt - io0, 1);
    rx_read("t5_rx0", 4'd0, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
